// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared definitions for the seq_tx serial pattern transmitter.
//               Holds the FSM state encoding (IDLE/SHIFT/DONE) and the
//               default widths for the pattern (W), length (LW) and
//               repeat (CW) fields.
// Config      : SEQ_TX_REPEAT_EN (used by seq_tx/seq_tx_if, not here)
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

  localparam int c_W_DEFAULT  = 8;
  localparam int c_LW_DEFAULT = 4;
  localparam int c_CW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_tx_if
// Description : Request/stream bundle between a requester (master) and the
//               seq_tx transmitter (slave).
//   start     : request to transmit (master -> slave)
//   pattern   : W-bit pattern, sent MSB-first
//   len       : LW-bit bits-per-pass (0 or >W means W)
//   rpt       : CW-bit number of extra passes (only with SEQ_TX_REPEAT_EN);
//               named rpt because 'repeat' is a reserved word
//   ready     : transmitter idle, start will be accepted
//   signal    : serial data bit
//   sig_valid : signal carries a pattern bit
//   done      : one-cycle end-of-transmission pulse
// Config      : SEQ_TX_REPEAT_EN adds rpt
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_tx_if
  import seq_pkg::*;
#(
  parameter int W  = c_W_DEFAULT,
  parameter int LW = c_LW_DEFAULT,
  parameter int CW = c_CW_DEFAULT
) ();

  logic          start;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
`ifdef SEQ_TX_REPEAT_EN
  logic [CW-1:0] rpt;
`endif
  logic          ready;
  logic          signal;
  logic          sig_valid;
  logic          done;

`ifdef SEQ_TX_REPEAT_EN
  modport master (output start, pattern, len, rpt,
                  input  ready, signal, sig_valid, done);
  modport slave  (input  start, pattern, len, rpt,
                  output ready, signal, sig_valid, done);
`else
  modport master (output start, pattern, len,
                  input  ready, signal, sig_valid, done);
  modport slave  (input  start, pattern, len,
                  output ready, signal, sig_valid, done);
`endif

endinterface
`default_nettype wire

// File: rtl/seq_tx_shreg.sv
`default_nettype none
// ============================================================================
// Module      : seq_tx_shreg
// Description : Loadable MSB-first shift register with bit down-counter and
//               last-bit flag. The owner emits the pattern MSB itself on the
//               load edge, so only the remaining W-1 bits are loaded here and
//               the counter holds the number of bits still to follow.
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load load_tail / load_len (priority over shift)
//   shift     : advance one bit
//   load_tail : pattern bits below the MSB
//   load_len  : effective pass length (1..W)
//   msb       : next bit to be emitted
//   last      : the bit currently being emitted is the last of the pass
// Revision    : 1.0 - initial release
// ============================================================================
module seq_tx_shreg
  import seq_pkg::*;
#(
  parameter int W  = c_W_DEFAULT,
  parameter int LW = c_LW_DEFAULT
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          load,
  input  wire logic          shift,
  input  wire logic [W-2:0]  load_tail,
  input  wire logic [LW-1:0] load_len,
  output logic               msb,
  output logic               last
);

  logic [W-2:0]  r_sh;
  logic [LW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_sh  <= load_tail;
      r_cnt <= load_len - LW'(1);
    end else if (shift) begin
      r_sh  <= r_sh << 1;
      r_cnt <= r_cnt - LW'(1);
    end
  end

  assign msb  = r_sh[W-2];
  assign last = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/seq_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_tx
// Description : Serial pattern transmitter. On start (while ready) the pattern
//               is sent MSB-first, one bit per cycle, for the effective
//               length; optionally repeated back-to-back without gaps, then a
//               one-cycle done pulse.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : seq_tx_if.slave (start/pattern/len[/rpt] in,
//               ready/signal/sig_valid/done out)
// Config      : SEQ_TX_REPEAT_EN - enables rpt input and pass counter
// Revision    : 1.0 - initial release
// ============================================================================
module seq_tx
  import seq_pkg::*;
#(
  parameter int W  = c_W_DEFAULT,
  parameter int LW = c_LW_DEFAULT,
  parameter int CW = c_CW_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst,
  seq_tx_if.slave   bus
);

  generate
    if (W < 2 || (2 ** LW) <= W || CW < 1) begin : g_param_check
      $error("seq_tx: need W>=2, 2**LW>W, CW>=1");
    end
  endgenerate

  state_t        r_state;
  logic          r_ready;
  logic          r_signal;
  logic          r_valid;
  logic          r_done;

  logic [LW-1:0] w_len_eff;
  logic          w_accept;
  logic          w_reload;
  logic          w_load;
  logic          w_shift;
  logic          w_msb;
  logic          w_last;
  logic [W-2:0]  w_load_tail;
  logic [LW-1:0] w_load_len;

  // len of 0 or beyond the register width means "whole pattern"
  assign w_len_eff = (bus.len == '0 || bus.len > LW'(W)) ? LW'(W) : bus.len;
  assign w_accept  = (r_state == IDLE) && bus.start;

`ifdef SEQ_TX_REPEAT_EN
  logic [CW-1:0] r_pass;
  logic [W-1:0]  r_cap_pat;
  logic [LW-1:0] r_cap_len;

  // Reload on the last bit of a non-final pass keeps the stream gap-free
  assign w_reload    = (r_state == SHIFT) && w_last && (r_pass != '0);
  assign w_load_tail = w_reload ? r_cap_pat[W-2:0] : bus.pattern[W-2:0];
  assign w_load_len  = w_reload ? r_cap_len : w_len_eff;
`else
  assign w_reload    = 1'b0;
  assign w_load_tail = bus.pattern[W-2:0];
  assign w_load_len  = w_len_eff;
`endif

  assign w_load  = w_accept || w_reload;
  assign w_shift = (r_state == SHIFT) && !w_last;

  seq_tx_shreg #(
    .W  (W),
    .LW (LW)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .shift     (w_shift),
    .load_tail (w_load_tail),
    .load_len  (w_load_len),
    .msb       (w_msb),
    .last      (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ready   <= 1'b1;
      r_signal  <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
`ifdef SEQ_TX_REPEAT_EN
      r_pass    <= '0;
      r_cap_pat <= '0;
      r_cap_len <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            // MSB goes straight to the output for latency 1
            r_state   <= SHIFT;
            r_ready   <= 1'b0;
            r_signal  <= bus.pattern[W-1];
            r_valid   <= 1'b1;
`ifdef SEQ_TX_REPEAT_EN
            r_pass    <= bus.rpt;
            r_cap_pat <= bus.pattern;
            r_cap_len <= w_len_eff;
`endif
          end
        end
        SHIFT: begin
          if (!w_last) begin
            r_signal <= w_msb;
          end
`ifdef SEQ_TX_REPEAT_EN
          else if (r_pass != '0) begin
            r_signal <= r_cap_pat[W-1];
            r_pass   <= r_pass - CW'(1);
          end
`endif
          else begin
            r_state  <= DONE;
            r_signal <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        DONE: begin
          // start seen here is ignored: ready is still low this cycle
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_ready  <= 1'b1;
          r_signal <= 1'b0;
          r_valid  <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.signal    = r_signal;
  assign bus.sig_valid = r_valid;
  assign bus.done      = r_done;

endmodule
`default_nettype wire
